mandelbrot_iter_sched: RTL
==========================

MANDELBROT_ITER_SCHED -- requirements
Module: mandelbrot_iter_sched

Interface
REQ-001 SHALL have parameter RESX, default 11'd640, frame width in pixels (1..2047).
REQ-002 SHALL have parameter RESY, default 11'd480, frame height in pixels (1..2047).
REQ-003 SHALL have parameter LAT, default 6, fixed datapath latency in cycles from issue to ret_escape (2..16).
REQ-004 SHALL have parameter IMAX, default 32'd255, maximum iteration count (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle frame start request.
REQ-008 SHALL have port busy  output  1  high while not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have ports issue_valid, issue_new  output  1 each  datapath issue strobe; new point (load x0,y0) vs recirculate.
REQ-011 SHALL have ports issue_x, issue_y  output  11 each  pixel coordinate of new point.
REQ-012 SHALL have port ret_escape  input  1  escape flag (xx+yy>4) for the point issued LAT cycles earlier.
REQ-013 SHALL have ports out_valid output 1, out_ready input 1, out_x/out_y output 11, out_v output 32  retired pixel stream.

Function
REQ-014 SHALL hold LAT slots {state EMPTY/ACTIVE/HELD, x, y, iter[31:0]}; a head pointer advances 0..LAT-1 every cycle, wrapping to 0.
REQ-015 SHALL run FSM IDLE->RUN on start; RUN->DRAIN the cycle the last pixel (RESX-1,RESY-1) issues; DRAIN->IDLE when all slots EMPTY and out_valid=0, pulsing done that cycle; start outside IDLE is ignored.
REQ-016 SHALL generate pixels in raster order: x increments 0..RESX-1, wraps to 0 and increments y; counters reset to 0 on entering RUN.
REQ-017 Head ACTIVE, ret_escape=0, iter+1<IMAX: SHALL issue recirculate (issue_valid=1, issue_new=0), iter<=iter+1.
REQ-018 Head ACTIVE and (ret_escape=1 or iter+1==IMAX): SHALL compute result v=iter+1 and attempt retire.
REQ-019 Retire SHALL succeed when out_valid=0 or out_ready=1: output register loads {x,y,v}, slot becomes EMPTY same cycle; otherwise slot becomes/stays HELD with v stored, issue_valid=0, retried on each later head visit.
REQ-020 Head EMPTY (including just-freed) in RUN: SHALL issue new point (issue_valid=1, issue_new=1, raster coordinate), slot ACTIVE, iter=0; in DRAIN/IDLE issue_valid=0.
REQ-021 ret_escape SHALL be ignored when head slot is EMPTY or HELD.
REQ-022 out_valid SHALL stay high with out_x/out_y/out_v stable until out_ready=1 sampled.
REQ-023 issue_* outputs SHALL be combinational from head slot state; out_* and done SHALL be registered.

Reset
REQ-024 rst SHALL asynchronously force: FSM IDLE, all slots EMPTY, head 0, raster counters 0, busy=0, done=0, out_valid=0, out_x=out_y=0, out_v=0, issue_valid=0; in-flight pixels discarded.

Configuration
REQ-025 With MANDELBROT_SCHED_STATS_EN defined SHALL add outputs stat_cycles[31:0] (cycles in RUN+DRAIN) and stat_iters[31:0] (sum of retired v), cleared on start and reset, saturating at 32'hFFFFFFFF; without it neither port nor counters exist and behaviour is otherwise identical.

Verification
REQ-026 RESX=2,RESY=1,LAT=4, ret_escape=1 constant, out_ready=1, start -> out (0,0,v=1) then (1,0,v=1), done one cycle, busy low after.
REQ-027 RESX=1,RESY=1,IMAX=3, ret_escape=0 -> one issue_new=1 plus exactly 2 recirculates, out_v=3.
REQ-028 RESX=4,RESY=1,LAT=4, escape=1, out_ready=0 for 20 cycles -> out_valid high with (0,0,1) stable, other slots HELD, no new issues; release -> remaining 3 pixels delivered, none lost or duplicated.
REQ-029 rst asserted mid-RUN -> all outputs zero immediately; next start restarts at issue (0,0).
REQ-030 start pulsed during RUN -> ignored, pixel count unchanged; with MANDELBROT_SCHED_STATS_EN, REQ-026 yields stat_iters=2.

Source files
------------

// File: rtl/mandelbrot_iter_sched.sv
// Mandelbrot iteration scheduler: LAT-slot recirculating pipeline feeding an external datapath.
// Optional per-frame statistics ports are enabled with `define MANDELBROT_SCHED_STATS_EN.
module mandelbrot_iter_sched #(
  parameter logic [10:0] RESX = 11'd640,
  parameter logic [10:0] RESY = 11'd480,
  parameter int          LAT  = 6,
  parameter logic [31:0] IMAX = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        issue_valid,
  output logic        issue_new,
  output logic [10:0] issue_x,
  output logic [10:0] issue_y,
  input  logic        ret_escape,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_x,
  output logic [10:0] out_y,
`ifdef MANDELBROT_SCHED_STATS_EN
  output logic [31:0] out_v,
  output logic [31:0] stat_cycles,
  output logic [31:0] stat_iters
`else
  output logic [31:0] out_v
`endif
);

  localparam int HW = (LAT <= 2) ? 1 : $clog2(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;
  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_HELD} slot_t;

  fsm_t          state, state_nxt;
  logic [HW-1:0] head;
  slot_t         st [LAT];
  logic [10:0]   sx [LAT];
  logic [10:0]   sy [LAT];
  logic [31:0]   sv [LAT];
  logic [10:0]   rx, ry;

  slot_t       hs;
  logic [10:0] hx, hy;
  logic [31:0] hv, iter_inc, v_ret;
  logic        recirc, retire_req, retire_ok, issue_new_c, last_pix, all_empty, done_nxt;

  // Head slot view; sv holds the iteration count while ACTIVE and the result while HELD.
  always_comb begin
    hs          = st[head];
    hx          = sx[head];
    hy          = sy[head];
    hv          = sv[head];
    iter_inc    = hv + 32'd1;
    recirc      = (hs == S_ACTIVE) && !ret_escape && (iter_inc < IMAX);
    retire_req  = ((hs == S_ACTIVE) && (ret_escape || (iter_inc >= IMAX))) || (hs == S_HELD);
    v_ret       = (hs == S_HELD) ? hv : iter_inc;
    retire_ok   = retire_req && (!out_valid || out_ready);
    issue_new_c = (state == RUN) && ((hs == S_EMPTY) || retire_ok);
    last_pix    = (rx == RESX - 11'd1) && (ry == RESY - 11'd1);
    issue_valid = recirc || issue_new_c;
    issue_new   = issue_new_c;
    issue_x     = issue_new_c ? rx : hx;
    issue_y     = issue_new_c ? ry : hy;
  end

  always_comb begin
    all_empty = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (st[i] != S_EMPTY) all_empty = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue_new_c && last_pix) state_nxt = DRAIN;
      DRAIN: begin
        if (all_empty && !out_valid) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      head  <= '0;
      rx    <= '0;
      ry    <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      head  <= (head == HW'(LAT - 1)) ? '0 : head + HW'(1);
      if ((state == IDLE) && start) begin
        rx <= '0;
        ry <= '0;
      end else if (issue_new_c) begin
        if (rx == RESX - 11'd1) begin
          rx <= '0;
          ry <= ry + 11'd1;
        end else begin
          rx <= rx + 11'd1;
        end
      end
    end
  end

  // A slot freed by a successful retire is refilled in the same cycle while in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        st[i] <= S_EMPTY;
        sx[i] <= '0;
        sy[i] <= '0;
        sv[i] <= '0;
      end
    end else begin
      if (issue_new_c) begin
        st[head] <= S_ACTIVE;
        sx[head] <= rx;
        sy[head] <= ry;
        sv[head] <= '0;
      end else if (recirc) begin
        sv[head] <= iter_inc;
      end else if (retire_ok) begin
        st[head] <= S_EMPTY;
      end else if (retire_req) begin
        st[head] <= S_HELD;
        sv[head] <= v_ret;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_v     <= '0;
    end else if (retire_ok) begin
      out_valid <= 1'b1;
      out_x     <= hx;
      out_y     <= hy;
      out_v     <= v_ret;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MANDELBROT_SCHED_STATS_EN
  logic [32:0] cyc_sum, iter_sum;

  always_comb begin
    cyc_sum  = {1'b0, stat_cycles} + 33'd1;
    iter_sum = {1'b0, stat_iters} + {1'b0, v_ret};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cycles <= '0;
      stat_iters  <= '0;
    end else if ((state == IDLE) && start) begin
      stat_cycles <= '0;
      stat_iters  <= '0;
    end else begin
      if (state != IDLE) stat_cycles <= cyc_sum[32] ? 32'hFFFF_FFFF : cyc_sum[31:0];
      if (retire_ok)     stat_iters  <= iter_sum[32] ? 32'hFFFF_FFFF : iter_sum[31:0];
    end
  end
`endif

endmodule
